// File: rtl/decode_pkg.sv
// decode_pkg: shared widths, the decoded-instruction record and the field
// splitter used by the decode stage.
//
// Contents:
//   width constants  OP_W, REG_W, FUNC_W, APB_ADDR_W, DEV_W, IMM_W, ADDR_W
//   derived          LOW_W, INST_W, APB_DATA_W, PFX_W (prefix field width)
//   decoded_t        all decoded output fields plus the illegal flag
//   decode_fields    pure combinational split of one instruction word
//
// Instruction layout, MSB first:
//   opcode[OP_W] | apb_addr[APB_ADDR_W] | rd[REG_W] | ra[REG_W] | rb[REG_W] | func[FUNC_W]
// apb_data and apb_device overlay the low LOW_W bits.
package decode_pkg;

    localparam int OP_W       = 4;
    localparam int REG_W      = 3;
    localparam int FUNC_W     = 3;
    localparam int APB_ADDR_W = 8;
    localparam int DEV_W      = 4;
    localparam int IMM_W      = 8;
    localparam int ADDR_W     = 8;

    localparam int LOW_W      = 3*REG_W + FUNC_W;
    localparam int INST_W     = OP_W + APB_ADDR_W + LOW_W;
    localparam int APB_DATA_W = LOW_W - DEV_W;
    localparam int PFX_W      = IMM_W - LOW_W/2;

    typedef struct packed {
        logic [OP_W-1:0]       opcode;
        logic [REG_W-1:0]      rd_addr;
        logic [REG_W-1:0]      ra_addr;
        logic [REG_W-1:0]      rb_addr;
        logic [FUNC_W-1:0]     func;
        logic [IMM_W-1:0]      imm;
        logic [ADDR_W-1:0]     addr;
        logic [APB_ADDR_W-1:0] apb_addr;
        logic [APB_DATA_W-1:0] apb_data;
        logic [DEV_W-1:0]      apb_device;
        logic                  illegal;
    } decoded_t;

    // The illegal flag depends on a per-instance mask, so it is left clear
    // here and filled in by the stage.
    function automatic decoded_t decode_fields(input logic [INST_W-1:0] inst);
        decoded_t                  d;
        logic [REG_W+FUNC_W-1:0]   imm_raw;
        logic [2*REG_W:0]          addr_raw;
        d.opcode     = inst[INST_W-1 -: OP_W];
        d.apb_addr   = inst[LOW_W +: APB_ADDR_W];
        d.rd_addr    = inst[LOW_W-1 -: REG_W];
        d.ra_addr    = inst[LOW_W-REG_W-1 -: REG_W];
        d.rb_addr    = inst[FUNC_W +: REG_W];
        d.func       = inst[FUNC_W-1:0];
        // rd's MSB is the sign of the {rd, func} immediate
        imm_raw      = {d.rd_addr, d.func};
        d.imm        = IMM_W'($signed(imm_raw));
        addr_raw     = inst[2*REG_W:0];
        d.addr       = ADDR_W'($signed(addr_raw));
        d.apb_data   = inst[LOW_W-1 -: APB_DATA_W];
        d.apb_device = inst[DEV_W-1:0];
        d.illegal    = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// decode_skid_buf: two-entry valid/ready pipeline register with a skid slot.
// The output register holds the head entry; the skid register catches one
// word accepted while the head is stalled. in_ready is a flop, so there is
// no combinational path from out_ready back to in_ready.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   flush                drop both entries and any word offered this cycle
//   in_valid / in_ready  upstream handshake (in_ready low during reset)
//   in_data              entry to store
//   out_valid/out_ready  downstream handshake
//   out_data             head entry, stable while stalled
module decode_skid_buf
    import decode_pkg::*;
#(
    parameter type data_t = decoded_t
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  flush,
    input  logic  in_valid,
    output logic  in_ready,
    input  data_t in_data,
    output logic  out_valid,
    input  logic  out_ready,
    output data_t out_data
);

    logic  ov, sv, ready_q;
    data_t out_q, skid_q;
    logic  drain, accept, ov_next, sv_next;
    data_t out_next, skid_next;

    // Next-state selection. The skid slot only fills while the head is
    // stalled, and in_ready is low whenever it is full, so a skid refill
    // and a fresh accept never collide.
    always_comb begin
        drain     = ov && out_ready;
        accept    = in_valid && ready_q;
        ov_next   = ov;
        sv_next   = sv;
        out_next  = out_q;
        skid_next = skid_q;
        if (flush) begin
            ov_next = 1'b0;
            sv_next = 1'b0;
        end else if (!ov || drain) begin
            if (sv) begin
                out_next = skid_q;
                ov_next  = 1'b1;
                sv_next  = 1'b0;
            end else if (accept) begin
                out_next = in_data;
                ov_next  = 1'b1;
            end else begin
                ov_next  = 1'b0;
            end
        end else if (accept) begin
            skid_next = in_data;
            sv_next   = 1'b1;
        end
    end

    // ready_q mirrors !sv except in reset, where it is forced low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ov      <= 1'b0;
            sv      <= 1'b0;
            ready_q <= 1'b0;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            ov      <= ov_next;
            sv      <= sv_next;
            ready_q <= !sv_next;
            out_q   <= out_next;
            skid_q  <= skid_next;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = ov;
    assign out_data  = out_q;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode between fetch and execute.
// Each accepted word is split into its fields by decode_pkg::decode_fields
// and queued in a two-entry skid buffer, giving one-cycle latency and full
// throughput with a registered in_ready.
//
// Optional feature macro: DECODE_PREFIX_EN. When defined, an instruction
// with opcode PREFIX_OP produces no output but latches upper immediate bits
// that replace the sign extension of the next decoded instruction.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 discard everything buffered (and the prefix)
//   in_valid/in_ready     fetch-side handshake, inst is the word
//   out_valid/out_ready   execute-side handshake
//   opcode, rd_addr, ra_addr, rb_addr, func, imm, addr,
//   apb_addr, apb_data, apb_device, illegal   decoded fields
//
// The width parameters must match the constants in decode_pkg, which fix
// the layout of decoded_t.
module decode_stage #(
    parameter int                               OP_W         = decode_pkg::OP_W,
    parameter int                               REG_W        = decode_pkg::REG_W,
    parameter int                               FUNC_W       = decode_pkg::FUNC_W,
    parameter int                               APB_ADDR_W   = decode_pkg::APB_ADDR_W,
    parameter int                               DEV_W        = decode_pkg::DEV_W,
    parameter int                               IMM_W        = decode_pkg::IMM_W,
    parameter int                               ADDR_W       = decode_pkg::ADDR_W,
    parameter logic [(1<<decode_pkg::OP_W)-1:0] ILLEGAL_MASK = 16'h0000,
    parameter logic [decode_pkg::OP_W-1:0]      PREFIX_OP    = 4'hF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [decode_pkg::INST_W-1:0]     inst,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [OP_W-1:0]                   opcode,
    output logic [REG_W-1:0]                  rd_addr,
    output logic [REG_W-1:0]                  ra_addr,
    output logic [REG_W-1:0]                  rb_addr,
    output logic [FUNC_W-1:0]                 func,
    output logic [IMM_W-1:0]                  imm,
    output logic [ADDR_W-1:0]                 addr,
    output logic [APB_ADDR_W-1:0]             apb_addr,
    output logic [decode_pkg::APB_DATA_W-1:0] apb_data,
    output logic [DEV_W-1:0]                  apb_device,
    output logic                              illegal
);

    import decode_pkg::*;

    decoded_t dec;
    decoded_t head;
    logic     push_valid;

`ifdef DECODE_PREFIX_EN
    logic             pfx_valid;
    logic [PFX_W-1:0] pfx;
    logic             is_prefix;
    logic             accept;

    assign is_prefix = (inst[INST_W-1 -: OP_W] == PREFIX_OP);
    assign accept    = in_valid && in_ready;

    // A pending prefix supplies the upper immediate bits in place of the
    // sign extension.
    always_comb begin
        dec         = decode_fields(inst);
        dec.illegal = ILLEGAL_MASK[dec.opcode];
        if (pfx_valid) begin
            dec.imm = {pfx, dec.rd_addr, dec.func};
        end
    end

    // Prefix words are consumed here and never reach the buffer.
    assign push_valid = in_valid && !is_prefix;

    // A later prefix overwrites an earlier one; the next real instruction
    // consumes it.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            pfx_valid <= 1'b0;
            pfx       <= '0;
        end else if (accept) begin
            if (is_prefix) begin
                pfx_valid <= 1'b1;
                pfx       <= inst[LOW_W +: PFX_W];
            end else begin
                pfx_valid <= 1'b0;
            end
        end
    end
`else
    logic unused_prefix_op;

    always_comb begin
        dec         = decode_fields(inst);
        dec.illegal = ILLEGAL_MASK[dec.opcode];
    end

    assign push_valid       = in_valid;
    assign unused_prefix_op = ^PREFIX_OP;
`endif

    decode_skid_buf #(
        .data_t (decoded_t)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (push_valid),
        .in_ready  (in_ready),
        .in_data   (dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign opcode     = head.opcode;
    assign rd_addr    = head.rd_addr;
    assign ra_addr    = head.ra_addr;
    assign rb_addr    = head.rb_addr;
    assign func       = head.func;
    assign imm        = head.imm;
    assign addr       = head.addr;
    assign apb_addr   = head.apb_addr;
    assign apb_data   = head.apb_data;
    assign apb_device = head.apb_device;
    assign illegal    = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage.
// A queue-based reference model tracks what the stage holds and checks
// every output on every falling edge; directed sequences pin literal
// values, then randomized traffic with flushes and resets follows.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] inst;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  opcode;
    logic [2:0]  rd_addr, ra_addr, rb_addr, func;
    logic [7:0]  imm, addr, apb_addr, apb_data;
    logic [3:0]  apb_device;
    logic        illegal;

    always #5 clk = ~clk;

    decode_stage #(
        .ILLEGAL_MASK (16'h0100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .inst       (inst),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .opcode     (opcode),
        .rd_addr    (rd_addr),
        .ra_addr    (ra_addr),
        .rb_addr    (rb_addr),
        .func       (func),
        .imm        (imm),
        .addr       (addr),
        .apb_addr   (apb_addr),
        .apb_data   (apb_data),
        .apb_device (apb_device),
        .illegal    (illegal)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int op; int aa; int rd; int ra; int rb; int fn;
        int imm; int addr; int ad; int dev; int ill;
    } exp_t;

    exp_t q[$];
    bit   exp_ready  = 1'b0;
    bit   after_rst  = 1'b1;
    bit   m_pfx_v    = 1'b0;
    int   m_pfx      = 0;

    // Field arithmetic straight from the instruction layout.
    function automatic exp_t model_decode(input int w, input bit pv, input int pf);
        exp_t e;
        int   raw6, a7;
        e.op   = (w >> 20) & 15;
        e.aa   = (w >> 12) & 255;
        e.rd   = (w >> 9) & 7;
        e.ra   = (w >> 6) & 7;
        e.rb   = (w >> 3) & 7;
        e.fn   = w & 7;
        raw6   = e.rd * 8 + e.fn;
        if (pv) e.imm = pf * 64 + raw6;
        else    e.imm = (raw6 >= 32) ? raw6 + 192 : raw6;
        a7     = w & 127;
        e.addr = (a7 >= 64) ? a7 + 128 : a7;
        e.ad   = (w >> 4) & 255;
        e.dev  = w & 15;
        e.ill  = (e.op == 8) ? 1 : 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rstn, input bit valid, input logic [23:0] w,
                                 input bit fl, input bit ordy);
        @(posedge clk);
        #1;
        rst_n     = rstn;
        in_valid  = valid;
        inst      = w;
        flush     = fl;
        out_ready = ordy;
    endtask

    // Compare against the model, then advance it to the state after the
    // coming rising edge using the inputs that edge will see.
    always @(negedge clk) begin
        exp_t e;
        bit   acc;
        checkOutput("in_ready", int'(in_ready), int'(exp_ready));
        checkOutput("out_valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
        if (q.size() > 0) begin
            e = q[0];
            checkOutput("opcode", int'(opcode), e.op);
            checkOutput("apb_addr", int'(apb_addr), e.aa);
            checkOutput("rd_addr", int'(rd_addr), e.rd);
            checkOutput("ra_addr", int'(ra_addr), e.ra);
            checkOutput("rb_addr", int'(rb_addr), e.rb);
            checkOutput("func", int'(func), e.fn);
            checkOutput("imm", int'(imm), e.imm);
            checkOutput("addr", int'(addr), e.addr);
            checkOutput("apb_data", int'(apb_data), e.ad);
            checkOutput("apb_device", int'(apb_device), e.dev);
            checkOutput("illegal", int'(illegal), e.ill);
        end else if (after_rst) begin
            checkOutput("rst_fields", int'({opcode, rd_addr, ra_addr, rb_addr, func}), 0);
            checkOutput("rst_imm_addr", int'({imm, addr, apb_addr, apb_data}), 0);
            checkOutput("rst_dev_illegal", int'({apb_device, illegal}), 0);
        end

        if (!rst_n) begin
            q.delete();
            exp_ready = 1'b0;
            after_rst = 1'b1;
            m_pfx_v   = 1'b0;
        end else begin
            after_rst = 1'b0;
            if (flush) begin
                q.delete();
                m_pfx_v = 1'b0;
            end else begin
                acc = in_valid && exp_ready;
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (acc) begin
`ifdef DECODE_PREFIX_EN
                    if (((int'(inst) >> 20) & 15) == 15) begin
                        m_pfx_v = 1'b1;
                        m_pfx   = (int'(inst) >> 12) & 3;
                    end else begin
                        q.push_back(model_decode(int'(inst), m_pfx_v, m_pfx));
                        m_pfx_v = 1'b0;
                    end
`else
                    q.push_back(model_decode(int'(inst), 1'b0, 0));
`endif
                end
            end
            exp_ready = (q.size() < 2);
        end
    end

    initial begin
        logic [23:0] w;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        inst      = '0;
        out_ready = 1'b0;

        // reset state
        @(negedge clk);
        checkOutput("reset_in_ready", int'(in_ready), 0);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_imm", int'(imm), 0);
        applyStimulus(1, 0, 24'h0, 0, 1);
        @(negedge clk);
        checkOutput("release_ready_lag", int'(in_ready), 0);

        // basic decode
        applyStimulus(1, 1, 24'h3A5C47, 0, 1);
        @(negedge clk);
        checkOutput("ready_after_release", int'(in_ready), 1);
        applyStimulus(1, 0, 24'h0, 0, 1);
        @(negedge clk);
        checkOutput("basic_valid", int'(out_valid), 1);
        checkOutput("basic_opcode", int'(opcode), 3);
        checkOutput("basic_apb_addr", int'(apb_addr), 8'hA5);
        checkOutput("basic_rd", int'(rd_addr), 6);
        checkOutput("basic_ra", int'(ra_addr), 1);
        checkOutput("basic_rb", int'(rb_addr), 0);
        checkOutput("basic_func", int'(func), 7);
        checkOutput("basic_imm", int'(imm), 8'hF7);
        checkOutput("basic_addr", int'(addr), 8'hC7);
        checkOutput("basic_apb_data", int'(apb_data), 8'hC4);
        checkOutput("basic_apb_device", int'(apb_device), 4'h7);
        checkOutput("basic_illegal", int'(illegal), 0);

        // backpressure: A, B accepted, C held until the output drains
        applyStimulus(1, 1, 24'h1B2001, 0, 0);
        applyStimulus(1, 1, 24'h2C3002, 0, 0);
        applyStimulus(1, 1, 24'h5D4003, 0, 0);
        @(negedge clk);
        checkOutput("bp_ready_low", int'(in_ready), 0);
        checkOutput("bp_head_a", int'(opcode), 1);
        applyStimulus(1, 1, 24'h5D4003, 0, 0);
        applyStimulus(1, 1, 24'h5D4003, 0, 1);
        @(negedge clk);
        checkOutput("bp_out_a", int'(apb_addr), 8'hB2);
        applyStimulus(1, 1, 24'h5D4003, 0, 1);
        @(negedge clk);
        checkOutput("bp_out_b", int'(apb_addr), 8'hC3);
        checkOutput("bp_ready_back", int'(in_ready), 1);
        applyStimulus(1, 0, 24'h0, 0, 1);
        @(negedge clk);
        checkOutput("bp_out_c", int'(apb_addr), 8'hD4);
        applyStimulus(1, 0, 24'h0, 0, 1);
        @(negedge clk);
        checkOutput("bp_empty", int'(out_valid), 0);

        // flush with both entries full
        applyStimulus(1, 1, 24'h611111, 0, 0);
        applyStimulus(1, 1, 24'h622222, 0, 0);
        applyStimulus(1, 0, 24'h0, 1, 0);
        @(negedge clk);
        checkOutput("flush_full", int'(in_ready), 0);
        applyStimulus(1, 0, 24'h0, 0, 1);
        @(negedge clk);
        checkOutput("flush_out_valid", int'(out_valid), 0);
        checkOutput("flush_in_ready", int'(in_ready), 1);
        applyStimulus(1, 0, 24'h0, 0, 1);
        @(negedge clk);
        checkOutput("flush_no_reappear", int'(out_valid), 0);

        // illegal mask bit 8
        applyStimulus(1, 1, 24'h812345, 0, 1);
        applyStimulus(1, 1, 24'h7ABCDE, 0, 1);
        @(negedge clk);
        checkOutput("illegal_op8", int'(illegal), 1);
        applyStimulus(1, 0, 24'h0, 0, 1);
        @(negedge clk);
        checkOutput("illegal_op7", int'(illegal), 0);
        checkOutput("illegal_op7_opcode", int'(opcode), 7);

        // reset mid-stream
        applyStimulus(1, 1, 24'h3A5C47, 0, 0);
        applyStimulus(1, 0, 24'h0, 0, 0);
        @(negedge clk);
        checkOutput("mid_valid", int'(out_valid), 1);
        applyStimulus(0, 0, 24'h0, 0, 0);
        applyStimulus(0, 0, 24'h0, 0, 0);
        @(negedge clk);
        checkOutput("mid_rst_valid", int'(out_valid), 0);
        checkOutput("mid_rst_imm", int'(imm), 0);
        checkOutput("mid_rst_ready", int'(in_ready), 0);
        applyStimulus(1, 0, 24'h0, 0, 0);
        @(negedge clk);
        checkOutput("mid_rel_ready_lag", int'(in_ready), 0);
        applyStimulus(1, 0, 24'h0, 0, 1);
        @(negedge clk);
        checkOutput("mid_rel_ready", int'(in_ready), 1);

`ifdef DECODE_PREFIX_EN
        // prefix then two ordinary words
        applyStimulus(1, 1, 24'hF01000, 0, 1);
        applyStimulus(1, 1, 24'h3A5C47, 0, 1);
        @(negedge clk);
        checkOutput("pfx_no_output", int'(out_valid), 0);
        applyStimulus(1, 1, 24'h3A5C47, 0, 1);
        @(negedge clk);
        checkOutput("pfx_imm", int'(imm), 8'h77);
        applyStimulus(1, 0, 24'h0, 0, 1);
        @(negedge clk);
        checkOutput("pfx_cleared_imm", int'(imm), 8'hF7);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            w = 24'($urandom);
            if ($urandom_range(0, 7) == 0) w[23:20] = 4'hF;
            applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, w,
                          $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
        end
        repeat (5) applyStimulus(1, 0, 24'h0, 0, 1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction decode stage.
- Splits each fetched instruction word into these fields: opcode, register addresses, function code, sign-extended immediate and branch address, and the APB address, data and device fields.
- Sits between fetch and execute, with a valid/ready handshake on both sides.
- A two-entry skid buffer gives full throughput while keeping in_ready registered.
- Flags illegal opcodes and supports flush.

Parameters:
- OP_W, 4, opcode width.
- REG_W, 3, register address width.
- FUNC_W, 3, function field width.
- APB_ADDR_W, 8, APB address field width.
- DEV_W, 4, APB device field width.
- IMM_W, 8, immediate output width; must be ≥ REG_W+FUNC_W.
- ADDR_W, 8, branch address output width; must be ≥ 2*REG_W+1.
- ILLEGAL_MASK, 16'h0000, one bit per opcode value; a set bit marks that opcode illegal.
- PREFIX_OP, 4'hF, opcode of the immediate-prefix instruction (used only with the optional feature).
- Derived constants:
  - LOW_W = 3*REG_W+FUNC_W.
  - INST_W = OP_W+APB_ADDR_W+LOW_W.
  - APB_DATA_W = LOW_W-DEV_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous discard of all buffered instructions.
- in_valid  in  1  inst is valid.
- in_ready  out  1  stage can accept inst.
- inst  in  INST_W  instruction word.
- out_valid  out  1  decoded fields are valid.
- out_ready  in  1  consumer accepts the fields.
- opcode  out  OP_W.
- rd_addr, ra_addr, rb_addr  out  REG_W each.
- func  out  FUNC_W.
- imm  out  IMM_W.
- addr  out  ADDR_W.
- apb_addr  out  APB_ADDR_W.
- apb_data  out  APB_DATA_W.
- apb_device  out  DEV_W.
- illegal  out  1  the opcode's bit is set in ILLEGAL_MASK.

Behaviour:
- Field extraction, with MSB first:
  - opcode = the top OP_W bits.
  - apb_addr = the next APB_ADDR_W bits.
  - The low LOW_W bits split as rd | ra | rb | func.
  - apb_data = inst[LOW_W-1 -: APB_DATA_W].
  - apb_device = inst[DEV_W-1:0].
  - imm = {rd, func} sign-extended to IMM_W, using rd's MSB as the sign.
  - addr = inst[2*REG_W:0] sign-extended to ADDR_W.
- Decoding is combinational on the input word. The result is registered into the output register or the skid register.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 instruction per cycle when out_ready=1.
- Storage: an output register (OV) plus one skid register (SV).
  - in_ready = !SV, driven from a register.
  - Accept happens when in_valid && in_ready.
  - If the output register is empty, or is draining this cycle, the accepted word loads the output register. Otherwise it loads the skid register.
  - When the output drains and SV=1, the skid entry moves to the output register in the same cycle.
- Ordering is strictly FIFO; nothing is dropped or duplicated.
- Output fields hold stable while out_valid && !out_ready.
- Flush:
  - Clears OV and SV at the next edge and drops any input arriving that cycle.
  - in_ready is 1 on the following cycle.
  - Flush takes priority over accept and drain.
- Reset (rst_n=0 at an edge):
  - out_valid=0, all field outputs=0, illegal=0, SV=0.
  - in_ready=0 while rst_n is low, and 1 on the first cycle after release.
  - Reset mid-transfer discards both entries.
- No combinational path from out_ready to in_ready.

Optional Feature:
- DECODE_PREFIX_EN defined:
  - An accepted instruction with opcode==PREFIX_OP produces no output.
  - It latches prefix = inst[LOW_W +: IMM_W-LOW_W/2] and sets pfx_valid.
  - The next non-prefix instruction decodes with imm = {prefix, rd, func}, without sign extension. pfx_valid clears when that instruction is accepted.
  - Consecutive prefixes: the later one overwrites the earlier.
  - Flush and reset clear pfx_valid.
- DECODE_PREFIX_EN undefined: PREFIX_OP decodes as an ordinary instruction and no prefix state exists.

Decomposition:
- Package decode_pkg holds:
  - the width constants and derived LOW_W, INST_W and APB_DATA_W;
  - a typedef struct decoded_t bundling all output fields and illegal;
  - the function decode_fields(inst) returning decoded_t.
- One sub-module, decode_skid_buf, holds a parametrised two-entry valid/ready skid of decoded_t.

Test Plan:
- Basic decode: inst=24'h3A5C47, out_ready=1 → next cycle:
  - opcode=3, apb_addr=8'hA5, rd=6, ra=1, rb=0, func=7;
  - imm=8'hF7, addr=8'hC7, apb_data=8'hC4, apb_device=4'h7, illegal=0.
- Backpressure:
  - out_ready=0; offer three words A, B, C → A and B are accepted and in_ready drops after B.
  - Raise out_ready → A, B, C emerge in order on consecutive cycles.
- Flush: with OV=SV=1, pulse flush → out_valid=0 next cycle and in_ready=1; neither held word reappears.
- Illegal: ILLEGAL_MASK=16'h0100, opcode 8 → illegal=1; opcode 7 → illegal=0.
- Reset mid-stream: assert rst_n=0 while out_valid=1 → out_valid=0, imm=0, and in_ready=0 until release.
- Prefix (DECODE_PREFIX_EN): F01000, then 3A5C47 → a single output with imm=8'h77. A second 3A5C47 → imm=8'hF7.
